// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32-cycle radix-2 engine,
// result in DONE at start+33 (start+1 for divide-by-zero/overflow), stalling the pipe meanwhile.
module ex_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        MulDivE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallMD,
  output logic        DoneMD,
  output logic [31:0] ResultMD
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, stateNext;
  logic [4:0]  count;
  logic [63:0] acc;       // mul: {product hi, multiplier/product lo}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic [2:0]  opR;
  logic        signAR, signBR;

  logic        isDiv, signedA, signedB, signA, signB, start;
  logic        divZero, divOvf, bypass;
  logic [31:0] magA, magB, bypassResult;
  logic [32:0] mulSum, shifted, trial;
  logic [63:0] mulNext, divNext, accNext, prodSigned;
  logic [31:0] finalResult;

  always_comb begin
    isDiv   = MulDivOpE[2];
    signedA = isDiv ? ~MulDivOpE[0] : (MulDivOpE != 3'b011);
    signedB = isDiv ? ~MulDivOpE[0] : ~MulDivOpE[1];
    signA   = signedA & SrcAE[31];
    signB   = signedB & SrcBE[31];
    magA    = signA ? 32'd0 - SrcAE : SrcAE;
    magB    = signB ? 32'd0 - SrcBE : SrcBE;
    divZero = isDiv && (SrcBE == 32'd0);
    divOvf  = isDiv && !MulDivOpE[0] && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    bypass  = divZero || divOvf;
    if (divZero) bypassResult = MulDivOpE[1] ? SrcAE : 32'hFFFF_FFFF;
    else         bypassResult = MulDivOpE[1] ? 32'd0 : 32'h8000_0000;
    start   = (state == IDLE) && MulDivE && !clear;
  end

  // One radix-2 step of each engine; the result is formed from the post-step value
  // so ResultMD is ready in the DONE cycle.
  always_comb begin
    mulSum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    mulNext = {mulSum, acc[31:1]};
    shifted = {acc[63:32], acc[31]};
    trial   = shifted - {1'b0, opnd};
    divNext = trial[32] ? {shifted[31:0], acc[30:0], 1'b0}
                        : {trial[31:0],   acc[30:0], 1'b1};
    accNext = opR[2] ? divNext : mulNext;
    prodSigned = (signAR ^ signBR) ? 64'd0 - accNext : accNext;
    case (opR)
      3'b000:         finalResult = prodSigned[31:0];
      3'b100, 3'b101: finalResult = (signAR ^ signBR) ? 32'd0 - accNext[31:0] : accNext[31:0];
      3'b110, 3'b111: finalResult = signAR ? 32'd0 - accNext[63:32] : accNext[63:32];
      default:        finalResult = prodSigned[63:32];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = bypass ? DONE : BUSY;
      BUSY:    if (count == 5'd31) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (clear) stateNext = IDLE;
  end

  always_comb begin
    StallMD = reset && !clear && ((state == BUSY) || ((state == IDLE) && MulDivE));
    DoneMD  = reset && !clear && (state == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      opR      <= 3'd0;
      signAR   <= 1'b0;
      signBR   <= 1'b0;
      ResultMD <= 32'd0;
    end else if (start) begin
      count  <= 5'd0;
      opR    <= MulDivOpE;
      signAR <= signA;
      signBR <= signB;
      opnd   <= isDiv ? magB : magA;
      acc    <= {32'd0, (isDiv ? magA : magB)};
      if (bypass) ResultMD <= bypassResult;
    end else if ((state == BUSY) && !clear) begin
      acc   <= accNext;
      count <= count + 5'd1;
      if (count == 5'd31) ResultMD <= finalResult;
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; port names SHALL follow the codebase: clock, reset.
REQ-002 The block SHALL expose these ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset; 0 = reset asserted
- clear  in  1  synchronous kill of the in-flight operation (branch/jump flush of EX)
- MulDivE  in  1  EX instruction is an M-extension op, from the ID/EX control register
- MulDivOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  in  32  operand rs1, post-forwarding
- SrcBE  in  32  operand rs2, post-forwarding
- StallMD  out  1  hazard-unit request to hold F/D/E and bubble M
- DoneMD  out  1  one-cycle pulse: ResultMD valid for the EX instruction
- ResultMD  out  32  result, muxed into ALUResultE by EX when DoneMD=1

Function
REQ-003 The FSM SHALL have the states IDLE, BUSY, DONE.
REQ-004 In IDLE with MulDivE=1 and clear=0 (cycle T), StallMD SHALL be 1 combinationally in T; operands, op and sign flags SHALL be captured at the edge ending T, and the next state SHALL be BUSY.
REQ-005 Operand preparation: MUL/MULH/DIV/REM treat both operands as signed, MULHSU treats SrcAE as signed and SrcBE as unsigned, and MULHU/DIVU/REMU treat both as unsigned; signed operands SHALL be converted to 32-bit magnitudes, and the result sign SHALL be recorded.
REQ-006 In BUSY, a 5-bit counter SHALL perform exactly 32 iterations, one per cycle (T+1..T+32), with StallMD=1 throughout.
REQ-007 Multiply SHALL be a radix-2 shift-add into a 64-bit product; MUL returns the low 32 bits and MULH/MULHSU/MULHU return the high 32 bits, after sign correction.
REQ-008 Divide SHALL be a radix-2 restoring divide producing a 32-bit quotient and remainder; the quotient sign SHALL be signA XOR signB and the remainder sign SHALL equal the dividend sign.
REQ-009 After the 32nd iteration the state SHALL be DONE (cycle T+33), with StallMD=0, DoneMD=1 and ResultMD valid; the next state SHALL be IDLE even if MulDivE is still 1.
REQ-010 Divide by zero SHALL bypass iteration and go IDLE -> DONE at T+1: DIV/DIVU return 0xFFFFFFFF, and REM/REMU return SrcAE.
REQ-011 Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) SHALL bypass iteration and go to DONE at T+1: DIV returns 0x80000000 and REM returns 0.
REQ-012 clear=1 in any state SHALL force IDLE at the next edge with DoneMD=0 and ResultMD unchanged; in that cycle StallMD SHALL be 0 and no start SHALL occur.
REQ-013 ResultMD SHALL hold its value until the next DONE.
REQ-014 A new op presented in the cycle after DONE SHALL start normally; back-to-back ops SHALL incur no extra idle cycle beyond DONE.
REQ-015 With MulDivE=0 in IDLE, StallMD and DoneMD SHALL be 0.

Reset
REQ-016 reset=0 SHALL immediately, regardless of the clock, force: state IDLE, counter 0, internal product/quotient/remainder registers 0, ResultMD 0, DoneMD 0, StallMD 0.
REQ-017 Reset asserted mid-operation SHALL abort the operation without a DoneMD pulse; after release, the block SHALL accept a new op on the first edge.

Verification
REQ-018 MUL 7 x 0xFFFFFFFD, start at T -> StallMD=1 T..T+32, DoneMD=1 at T+33, ResultMD=0xFFFFFFEB.
REQ-019 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ResultMD=0xFFFFFFFE at T+33; MULH with the same operands -> 0x00000000.
REQ-020 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; each DONE at T+33.
REQ-021 DIVU 0x1234 / 0 -> DONE at T+1, ResultMD=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> DONE at T+1, ResultMD=0x80000000.
REQ-022 clear=1 at T+10 of a MUL -> IDLE at T+11, no DoneMD, ResultMD unchanged, StallMD=0 from T+10.
REQ-023 reset=0 at T+5 of a DIV -> all outputs 0 asynchronously; after release, DIVU 100 / 7 -> ResultMD=14 at start+33.
